// File: rtl/motor_ramp_seq.sv
// Differential-drive ramp sequencer.
// Slews the left/right drive commands toward latched targets by at most STEP
// per update, with one update every TICK cycles. An emergency stop forces both
// outputs to zero and parks the sequencer in BRAKE.
module motor_ramp_seq #(
   parameter int unsigned STEP = 16,
   parameter int unsigned TICK = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_vld,
   output logic               cmd_rdy,
   input  logic signed [10:0] tgt_lft,
   input  logic signed [10:0] tgt_rht,
   input  logic               estop,
   output logic signed [10:0] lft,
   output logic signed [10:0] rht,
   output logic               busy,
   output logic               done
);

   localparam int unsigned DW = 11;
   localparam int unsigned TW = 16;

   localparam logic [TW-1:0]        TICK_LAST = TW'(TICK - 1);
   localparam logic signed [DW:0]   STEP_S    = 12'(STEP);
   localparam logic signed [DW-1:0] TGT_NEG   = 11'sh400;  // -1024
   localparam logic signed [DW-1:0] TGT_MIN   = 11'sh401;  // -1023

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RAMP  = 2'd1,
      S_BRAKE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic signed [DW-1:0] lft_q, lft_d;
   logic signed [DW-1:0] rht_q, rht_d;
   logic signed [DW-1:0] tl_q, tl_d;
   logic signed [DW-1:0] tr_q, tr_d;
   logic [TW-1:0]        tick_q, tick_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;

   // Keep magnitudes within 10 bits so negation is always representable.
   function automatic logic signed [DW-1:0] clamp_tgt(input logic signed [DW-1:0] v);
      return (v == TGT_NEG) ? TGT_MIN : v;
   endfunction

   // One slew step toward tgt; the 12-bit difference cannot wrap.
   function automatic logic signed [DW-1:0] step_toward(input logic signed [DW-1:0] cur,
                                                        input logic signed [DW-1:0] tgt);
      logic signed [DW:0] diff;
      diff = {tgt[DW-1], tgt} - {cur[DW-1], cur};
      if (diff > STEP_S) begin
         return cur + STEP_S[DW-1:0];
      end else if (diff < -STEP_S) begin
         return cur - STEP_S[DW-1:0];
      end
      return tgt;
   endfunction

   // Next-state, slew and handshake logic; estop overrides everything.
   always_comb begin
      state_d = state_q;
      lft_d   = lft_q;
      rht_d   = rht_q;
      tl_d    = tl_q;
      tr_d    = tr_q;
      tick_d  = tick_q;
      done_d  = 1'b0;
      cmd_rdy = (state_q == S_IDLE) && !estop;

      if (estop) begin
         state_d = S_BRAKE;
         lft_d   = '0;
         rht_d   = '0;
         tl_d    = '0;
         tr_d    = '0;
         tick_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cmd_vld) begin
                  tl_d    = clamp_tgt(tgt_lft);
                  tr_d    = clamp_tgt(tgt_rht);
                  tick_d  = '0;
                  state_d = S_RAMP;
               end
            end
            S_RAMP: begin
               if ((lft_q == tl_q) && (rht_q == tr_q)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  tick_d  = '0;
               end else if (tick_q == TICK_LAST) begin
                  tick_d = '0;
                  lft_d  = step_toward(lft_q, tl_q);
                  rht_d  = step_toward(rht_q, tr_q);
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            S_BRAKE: begin
               state_d = S_IDLE;
               lft_d   = '0;
               rht_d   = '0;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         lft_q   <= '0;
         rht_q   <= '0;
         tl_q    <= '0;
         tr_q    <= '0;
         tick_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lft_q   <= lft_d;
         rht_q   <= rht_d;
         tl_q    <= tl_d;
         tr_q    <= tr_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign lft  = lft_q;
   assign rht  = rht_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
